// File: rtl/connect4_pkg.sv
// connect4_pkg: shared constants and types for the Connect-4 board slice.
// Holds the board geometry, the 2-bit piece codes, the requester indices of
// the board read arbiter, the arbiter state encoding and a helper that flags
// cell addresses lying outside the 6x7 board.
package connect4_pkg;

  localparam int BOARD_ROWS = 6;
  localparam int BOARD_COLS = 7;
  localparam int ROW_W      = 3;
  localparam int COL_W      = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } piece_e;

  localparam int REQ_GAME    = 0;
  localparam int REQ_DEBUG   = 1;
  localparam int REQ_DISPLAY = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // True when the cell address does not exist on the board.
  function automatic logic addr_oob(input logic [ROW_W-1:0] row,
                                    input logic [COL_W-1:0] col);
    return (row >= ROW_W'(BOARD_ROWS)) || (col >= COL_W'(BOARD_COLS));
  endfunction

endpackage

// File: rtl/board_read_arbiter_if.sv
// board_read_arbiter_if: requester-side bundle of the board read arbiter.
//   req       per-requester read request (held until granted)
//   req_lock  keep ownership after this grant (scan burst)
//   req_row   packed row addresses, requester i at [3i+2:3i]
//   req_col   packed column addresses, same packing
//   gnt       one-hot grant, same cycle as the accepted request
//   rsp_valid one-hot response strobe, one cycle after gnt
//   rsp_data  piece code of the granted cell (shared)
//   rsp_oob   granted address was outside the board
// master = requesters, slave = arbiter.
interface board_read_arbiter_if
  import connect4_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_lock;
  logic [ROW_W*NUM_REQ-1:0] req_row;
  logic [COL_W*NUM_REQ-1:0] req_col;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [1:0]               rsp_data;
  logic                     rsp_oob;

  modport master (
    output req, req_lock, req_row, req_col,
    input  gnt, rsp_valid, rsp_data, rsp_oob
  );

  modport slave (
    input  req, req_lock, req_row, req_col,
    output gnt, rsp_valid, rsp_data, rsp_oob
  );

endinterface

// File: rtl/board_read_arbiter_rr_pick.sv
// rr_pick: combinational one-hot picker.
//   req_i    request vector
//   ptr_i    index where the search starts (0 gives fixed priority)
//   demote_i requesters pushed to lowest priority
//   gnt_o    one-hot winner, idx_o its index, any_o set when a winner exists
// Non-demoted requesters are searched first from ptr_i upward (wrapping);
// demoted ones only win when nobody else is asking.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  demote_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  // Two-pass rotating search: pass 0 normal requesters, pass 1 demoted ones.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < N; k++) begin
        j = (int'(ptr_i) + k) % N;
        if (!any_o && req_i[j] && (demote_i[j] == (pass == 1))) begin
          any_o    = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = IW'(j);
        end else begin
          any_o = any_o;
        end
      end
    end
  end

endmodule

// File: rtl/board_read_arbiter.sv
// board_read_arbiter: shares the combinational board read port between the
// game engine (0), debug controller (1) and display renderer (2).
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          requester bundle (board_read_arbiter_if.slave)
//   b_read_o     board read strobe (= |gnt)
//   b_row_o      board row of the granted requester, else 0
//   b_col_o      board column of the granted requester, else 0
//   b_piece_i    board data, combinational from b_row_o/b_col_o
// Grants are combinational; the response is registered one cycle later.
// A granted requester with req_lock keeps the port (BURST) for at most
// MAX_BURST consecutive grants; a forced release demotes it for one
// arbitration.
// Build option: define BOARD_ARB_RR_EN for round-robin arbitration in IDLE;
// otherwise fixed priority (lowest index wins) and no pointer register.
module board_read_arbiter
  import connect4_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  board_read_arbiter_if.slave bus,
  output logic             b_read_o,
  output logic [ROW_W-1:0] b_row_o,
  output logic [COL_W-1:0] b_col_o,
  input  logic [1:0]       b_piece_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = 4;

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      count_q, count_d;
  logic [NUM_REQ-1:0] demote_q, demote_d;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [1:0]         rsp_data_q;
  logic               rsp_oob_q;

  logic [IW-1:0]      pick_ptr_s;
  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_any_s;
  logic               burst_hold_s;
  logic [CW-1:0]      count_inc_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [NUM_REQ-1:0] gnt_out_s;
  logic [IW-1:0]      gnt_idx_s;
  logic [ROW_W-1:0]   sel_row_s;
  logic [COL_W-1:0]   sel_col_s;
  logic               oob_s;

`ifdef BOARD_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  assign pick_ptr_s = ptr_q;
`else
  assign pick_ptr_s = '0;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (pick_ptr_s),
    .demote_i (demote_q),
    .gnt_o    (pick_gnt_s),
    .idx_o    (pick_idx_s),
    .any_o    (pick_any_s)
  );

  // The owner keeps the port only while it still requests; once it drops req
  // the same cycle falls through to normal arbitration.
  assign burst_hold_s = (state_q == ST_BURST) && bus.req[owner_q];
  assign count_inc_s  = count_q + CW'(1);

  // Grant selection and next-state computation.
  always_comb begin
    gnt_s     = '0;
    gnt_idx_s = owner_q;
    state_d   = state_q;
    owner_d   = owner_q;
    count_d   = count_q;
    demote_d  = demote_q;
`ifdef BOARD_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    if (burst_hold_s) begin
      gnt_s = NUM_REQ'(1) << owner_q;
      if (count_inc_s == CW'(MAX_BURST)) begin
        // Burst budget used up: release and push the owner to the back.
        state_d  = ST_IDLE;
        count_d  = '0;
        demote_d = NUM_REQ'(1) << owner_q;
      end else if (!bus.req_lock[owner_q]) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else begin
        state_d = ST_BURST;
        count_d = count_inc_s;
      end
    end else if (pick_any_s) begin
      gnt_s     = pick_gnt_s;
      gnt_idx_s = pick_idx_s;
      demote_d  = '0;
`ifdef BOARD_ARB_RR_EN
      ptr_d = (pick_idx_s == IW'(NUM_REQ - 1)) ? '0 : pick_idx_s + IW'(1);
`endif
      if (bus.req_lock[pick_idx_s]) begin
        state_d = ST_BURST;
        owner_d = pick_idx_s;
        count_d = CW'(1);
      end else begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    end else begin
      state_d = ST_IDLE;
      count_d = '0;
    end
  end

  // Reset forces the combinational outputs quiet too, so a held request
  // cannot show a grant while the arbiter is in reset.
  assign gnt_out_s = gnt_s & {NUM_REQ{rst_n}};
  assign sel_row_s = bus.req_row[ROW_W*gnt_idx_s +: ROW_W];
  assign sel_col_s = bus.req_col[COL_W*gnt_idx_s +: COL_W];
  assign oob_s     = addr_oob(sel_row_s, sel_col_s);

  assign b_read_o = |gnt_out_s;
  assign b_row_o  = (b_read_o && !oob_s) ? sel_row_s : '0;
  assign b_col_o  = (b_read_o && !oob_s) ? sel_col_s : '0;

  assign bus.gnt       = gnt_out_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_oob   = rsp_oob_q;

  // Arbiter state and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      count_q     <= '0;
      demote_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 2'b00;
      rsp_oob_q   <= 1'b0;
`ifdef BOARD_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      count_q     <= count_d;
      demote_q    <= demote_d;
      rsp_valid_q <= gnt_s;
`ifdef BOARD_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
      if (|gnt_s) begin
        rsp_data_q <= oob_s ? 2'(EMPTY) : b_piece_i;
        rsp_oob_q  <= oob_s;
      end else begin
        rsp_data_q <= rsp_data_q;
        rsp_oob_q  <= rsp_oob_q;
      end
    end
  end

endmodule

// File: tb/tb_board_read_arbiter.sv
// tb_board_read_arbiter: scoreboard bench for board_read_arbiter.
// Stimulus drives requests on the falling edge, predicts the grant from a
// behavioural arbiter model and queues the expected response; a separate
// monitor pops and compares whenever rsp_valid is seen.
module tb_board_read_arbiter;
  import connect4_pkg::*;

  localparam int N  = 3;
  localparam int MB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  board_read_arbiter_if #(.NUM_REQ(N)) bus ();

  logic       b_read;
  logic [2:0] b_row;
  logic [2:0] b_col;
  logic [1:0] b_piece;
  logic [1:0] board [8][8];

  always_comb b_piece = board[b_row][b_col];

  board_read_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .b_read_o  (b_read),
    .b_row_o   (b_row),
    .b_col_o   (b_col),
    .b_piece_i (b_piece)
  );

  typedef struct {
    int idx;
    int data;
    int oob;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_locked;
  int m_owner, m_count, m_ptr, m_demoted;
  int last_win;

  task automatic model_reset();
    m_locked  = 1'b0;
    m_owner   = 0;
    m_count   = 0;
    m_ptr     = 0;
    m_demoted = -1;
  endtask

  task automatic model_step(input logic [2:0] r, input logic [2:0] l, output int win);
    int start, j;
    win = -1;
    if (m_locked && r[m_owner]) begin
      win = m_owner;
      m_count++;
      if (m_count == MB) begin
        m_locked  = 1'b0;
        m_demoted = m_owner;
      end else if (!l[m_owner]) begin
        m_locked = 1'b0;
      end
    end else begin
      m_locked = 1'b0;
`ifdef BOARD_ARB_RR_EN
      start = m_ptr;
`else
      start = 0;
`endif
      for (int k = 0; k < N; k++) begin
        j = (start + k) % N;
        if (win < 0 && r[j] && j != m_demoted) win = j;
      end
      if (win < 0 && m_demoted >= 0 && r[m_demoted]) win = m_demoted;
      if (win >= 0) begin
        m_demoted = -1;
        m_ptr     = (win + 1) % N;
        if (l[win]) begin
          m_locked = 1'b1;
          m_owner  = win;
          m_count  = 1;
        end
      end
    end
  endtask

  // One bus cycle: drive, predict, check combinational side, queue response.
  task automatic cycle(input logic [2:0] r, input logic [2:0] l,
                       input logic [8:0] rows, input logic [8:0] cols);
    int w, row, col;
    bit oob;
    @(negedge clk);
    bus.req      = r;
    bus.req_lock = l;
    bus.req_row  = rows;
    bus.req_col  = cols;
    #1;
    model_step(r, l, w);
    last_win = w;
    row = 0;
    col = 0;
    oob = 1'b0;
    if (w >= 0) begin
      row = int'(rows[3*w +: 3]);
      col = int'(cols[3*w +: 3]);
      oob = (row >= 6) || (col >= 7);
    end
    chk("gnt", int'(bus.gnt), (w < 0) ? 0 : (1 << w));
    chk("b_read", int'(b_read), (w >= 0) ? 1 : 0);
    chk("b_row", int'(b_row), (w >= 0 && !oob) ? row : 0);
    chk("b_col", int'(b_col), (w >= 0 && !oob) ? col : 0);
    if (w >= 0) exp_q.push_back('{w, oob ? 0 : int'(board[row][col]), int'(oob)});
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_gnt"}, int'(bus.gnt), 0);
    chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    chk({tag, "_rsp_data"}, int'(bus.rsp_data), 0);
    chk({tag, "_rsp_oob"}, int'(bus.rsp_oob), 0);
    chk({tag, "_b_read"}, int'(b_read), 0);
    chk({tag, "_b_row"}, int'(b_row), 0);
    chk({tag, "_b_col"}, int'(b_col), 0);
  endtask

  // Response monitor.
  always @(posedge clk) begin
    #1;
    if (bus.rsp_valid != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", int'(bus.rsp_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_valid", int'(bus.rsp_valid), 1 << mon_e.idx);
        chk("rsp_data", int'(bus.rsp_data), mon_e.data);
        chk("rsp_oob", int'(bus.rsp_oob), mon_e.oob);
      end
    end
  end

  logic [2:0] r, l;
  logic [8:0] rows, cols;

  initial begin
    bus.req      = 3'b000;
    bus.req_lock = 3'b000;
    bus.req_row  = 9'd0;
    bus.req_col  = 9'd0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++)
        board[i][k] = 2'($urandom_range(0, 2));
    board[2][3] = 2'(P1);
    board[0][0] = 2'(P2);
    model_reset();
    last_win = -1;

    #2 rst_n = 1'b0;
    #1 check_quiet("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All three requesting continuously.
    for (int k = 0; k < 6; k++) begin
      cycle(3'b111, 3'b000, 9'd0, 9'd0);
`ifdef BOARD_ARB_RR_EN
      chk("rotate", int'(bus.gnt), 1 << (k % 3));
`else
      chk("fixed_pri", int'(bus.gnt), 1);
`endif
    end
    cycle(3'b000, 3'b000, 9'd0, 9'd0);

    // Game burst of 4 while display waits.
    for (int k = 0; k < 4; k++) begin
      cycle(3'b101, (k < 3) ? 3'b001 : 3'b000, 9'd0, 9'd0);
      chk("burst4_game", int'(bus.gnt), 1);
    end
    cycle(3'b100, 3'b000, 9'd0, 9'd0);
    chk("burst4_display", int'(bus.gnt), 4);
    cycle(3'b000, 3'b000, 9'd0, 9'd0);

    // Single debug read of row 2 col 3 holding P1.
    cycle(3'b010, 3'b000, {3'd0, 3'd2, 3'd0}, {3'd0, 3'd3, 3'd0});
    chk("single_gnt", int'(bus.gnt), 2);
    chk("single_row", int'(b_row), 2);
    chk("single_col", int'(b_col), 3);
    @(posedge clk);
    #1;
    chk("single_rsp_valid", int'(bus.rsp_valid), 2);
    chk("single_rsp_data", int'(bus.rsp_data), 1);
    chk("single_rsp_oob", int'(bus.rsp_oob), 0);
    cycle(3'b000, 3'b000, 9'd0, 9'd0);

    // Game holds lock forever with debug waiting: forced release after 8.
    for (int k = 0; k < MB; k++) begin
      cycle(3'b011, 3'b001, 9'd0, 9'd0);
      chk("forced_game", int'(bus.gnt), 1);
    end
    cycle(3'b011, 3'b001, 9'd0, 9'd0);
    chk("forced_debug", int'(bus.gnt), 2);
    cycle(3'b001, 3'b001, 9'd0, 9'd0);
    chk("forced_regain", int'(bus.gnt), 1);
    cycle(3'b000, 3'b000, 9'd0, 9'd0);

    // Out-of-range address: row 6 col 0.
    cycle(3'b001, 3'b000, {3'd0, 3'd0, 3'd6}, 9'd0);
    chk("oob_b_read", int'(b_read), 1);
    chk("oob_b_row", int'(b_row), 0);
    chk("oob_b_col", int'(b_col), 0);
    @(posedge clk);
    #1;
    chk("oob_rsp_oob", int'(bus.rsp_oob), 1);
    chk("oob_rsp_data", int'(bus.rsp_data), 0);
    cycle(3'b000, 3'b000, 9'd0, 9'd0);

    // Reset during burst cycle 3.
    cycle(3'b001, 3'b001, 9'd0, 9'd0);
    cycle(3'b001, 3'b001, 9'd0, 9'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_quiet("rst_mid");
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("rst_hold_rsp_valid", int'(bus.rsp_valid), 0);
    bus.req      = 3'b000;
    bus.req_lock = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_rsp_valid", int'(bus.rsp_valid), 0);
    cycle(3'b111, 3'b000, 9'd0, 9'd0);
    chk("post_rst_ptr0", int'(bus.gnt), 1);
    cycle(3'b000, 3'b000, 9'd0, 9'd0);

    // Randomized requesters obeying the hold-until-granted contract.
    r    = 3'b000;
    l    = 3'b000;
    rows = 9'd0;
    cols = 9'd0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!r[i] || last_win == i) begin
          r[i]          = ($urandom_range(0, 99) < 60);
          rows[3*i +: 3] = 3'($urandom_range(0, 6));
          cols[3*i +: 3] = 3'($urandom_range(0, 7));
        end
        l[i] = ($urandom_range(0, 99) < 70);
      end
      cycle(r, l, rows, cols);
    end
    cycle(3'b000, 3'b000, 9'd0, 9'd0);
    cycle(3'b000, 3'b000, 9'd0, 9'd0);
    chk("pending_rsp", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/board_read_arbiter.md
# board_read_arbiter

Shares the single combinational read port of the board store between the game engine (win/drop checker), the debug controller and the display renderer. Each requester presents a cell address with a request. The arbiter grants at most one request per cycle and drives the board port. It returns the registered 2-bit piece code one cycle later. A lock input lets the current owner hold the port for a short scan burst, bounded by a forced-release counter.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; index 0 = game, 1 = debug, 2 = display
- MAX_BURST, 8, maximum consecutive grants to one locked owner (2..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester read request; held until granted
- req_lock  in  NUM_REQ  keep ownership after this grant (burst)
- req_row  in  3*NUM_REQ  packed row address, requester i at [3i+2:3i]
- req_col  in  3*NUM_REQ  packed column address, same packing
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted request
- rsp_valid  out  NUM_REQ  one-hot, registered; high the cycle after gnt
- rsp_data  out  2  piece code of granted cell, registered, shared by all requesters
- rsp_oob  out  1  registered; address was out of range (row>=6 or col>=7)
- b_read  out  1  board read strobe, equals |gnt
- b_row  out  3  board row address, from the granted requester, else 0
- b_col  out  3  board column address, from the granted requester, else 0
- b_piece  in  2  board read data, combinational from b_row/b_col

## Operation
- Requester contract:
  - Assert req with a stable address.
  - The request completes in the cycle gnt[i]=1.
  - Data arrives with rsp_valid[i] in the next cycle.
  - req may stay high for back-to-back reads; each gnt cycle is one read.
- States:
  - IDLE: arbitrate among all active req bits.
  - BURST: only the owner can be granted.
- IDLE -> BURST: the granted requester has req_lock=1; owner index latched; burst count = 1.
- In BURST:
  - Owner req=1: gnt to owner; count++.
  - Owner req_lock=0 on a granted cycle: that is the last burst grant; next state IDLE.
  - Owner drops req: BURST exits; IDLE arbitration happens in the same cycle among other requesters.
  - count reaches MAX_BURST: forced IDLE next cycle; owner becomes lowest priority for the next arbitration, regardless of mode.
- req_lock from a non-owner is ignored.
- Out-of-range address:
  - Still consumes a grant slot; b_read=1.
  - Board is addressed at 0,0.
  - Response: rsp_data=2'b00, rsp_oob=1.
- Fairness: see Configuration.
- The round-robin pointer advances to (granted index + 1) mod NUM_REQ on every IDLE grant; BURST grants do not move it.

## Timing
- Grant and board address are combinational from req/state. Read latency is 1 cycle from gnt to rsp_valid/rsp_data.
- Throughput: one read per cycle, sustained.
- Reset values:
  - gnt=0, rsp_valid=0, rsp_data=0, rsp_oob=0
  - b_read=0, b_row=0, b_col=0
  - state IDLE, pointer 0, count 0, forced-low-priority flag clear
- Reset mid-burst: everything returns to the reset state immediately, and no response is issued for the in-flight grant.
- rsp_data/rsp_oob hold their last value when rsp_valid=0.
- No req: all outputs are 0 except held rsp_data/rsp_oob.

## Configuration
- BOARD_ARB_RR_EN defined: round-robin arbitration in IDLE, starting search at the pointer.
- BOARD_ARB_RR_EN undefined: fixed priority, lowest index wins; the pointer logic is removed.
- Forced-release demotion of a burst owner applies in both modes.

## Structure
- Shared package connect4_pkg holds:
  - BOARD_ROWS=6, BOARD_COLS=7
  - piece codes EMPTY=2'b00, P1=2'b01, P2=2'b10
  - requester indices REQ_GAME=0, REQ_DEBUG=1, REQ_DISPLAY=2
  - row/col width constants
- One sub-module: rr_pick. It is a combinational one-hot picker taking the request vector, start pointer and a demote mask. Fixed-priority mode ties the pointer to 0.

## Test plan
- Single read: debug req, row 2 col 3, board holds P1 -> gnt[1] same cycle, b_row=2 b_col=3; next cycle rsp_valid=3'b010, rsp_data=2'b01, rsp_oob=0.
- All three req continuously (RR_EN) -> grants rotate 0,1,2,0,1,2 and one rsp_valid per cycle; without the macro -> gnt[0] every cycle.
- Game locks burst of 4 while display requests -> 4 consecutive gnt[0] (lock dropped on the 4th), then gnt[2].
- Game holds lock indefinitely with MAX_BURST=8 and debug waiting -> exactly 8 gnt[0], then gnt[1], then game regains.
- Out of range: row 6 col 0 -> gnt, b_row=0 b_col=0; next cycle rsp_oob=1, rsp_data=0.
- rst_n low during burst cycle 3 -> all outputs 0 at once, no rsp_valid after release, and the first post-reset arbitration starts from pointer 0.
